// File: rtl/sd_boot_writer.sv
// Takes words from the SD sector loader handshake and writes them to memory through a single-outstanding req/ack port.
// Keeps a word count and a running checksum, and raises sticky overflow, timeout and load-done flags.
module sd_boot_writer #(
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                MAX_WORDS   = 1048576,
  parameter int                TIMEOUT_CYC = 65535
) (
  input  logic              clk27mhz,
  input  logic              resetn,
  input  logic [31:0]       i_data,
  input  logic              i_we,
  input  logic              i_done,
  output logic [7:0]        o_ctrl_state,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  output logic [31:0]       o_word_cnt,
  output logic [31:0]       o_checksum,
  output logic              o_load_done,
  output logic              o_overflow,
  output logic              o_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RELEASE  = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  // The state encoding is the loader-visible handshake value.
  assign o_ctrl_state = {6'd0, state};

  always_ff @(posedge clk27mhz or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      timer       <= '0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= BASE_ADDR;
      o_mem_wdata <= '0;
      o_word_cnt  <= '0;
      o_checksum  <= '0;
      o_load_done <= 1'b0;
      o_overflow  <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!o_load_done && i_done) begin
            o_load_done <= 1'b1;
            state       <= FINISHED;
          end else if (i_we) begin
            o_mem_wdata <= i_data;
            if (o_word_cnt == 32'(MAX_WORDS)) begin
              o_overflow <= 1'b1;
              state      <= RELEASE;
            end else begin
              o_mem_req <= 1'b1;
              timer     <= '0;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          if (i_mem_ack) begin
            o_mem_req  <= 1'b0;
            o_word_cnt <= o_word_cnt + 32'd1;
            o_checksum <= o_checksum + o_mem_wdata;
            o_mem_addr <= o_mem_addr + ADDR_W'(4);
            state      <= RELEASE;
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            o_mem_req <= 1'b0;
            o_timeout <= 1'b1;
            state     <= RELEASE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RELEASE: begin
          if (!i_we) state <= IDLE;
        end
        FINISHED: state <= FINISHED;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_boot_writer.sv
// Randomized loader/memory stimulus against a word-level model; a monitor checks every memory request
// against a queue of expected writes.
module tb_sd_boot_writer;

  localparam int          AW   = 28;
  localparam logic [27:0] BASE = 28'h0000100;
  localparam int          MAXW = 6;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] i_data;
  logic        i_we, i_done, mem_ack;
  logic [7:0]  ctrl;
  logic        mem_req;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata, word_cnt, checksum;
  logic        load_done, overflow, timeout;

  always #5 clk = ~clk;

  sd_boot_writer #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk27mhz(clk), .resetn(resetn), .i_data(i_data), .i_we(i_we), .i_done(i_done),
    .o_ctrl_state(ctrl), .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .o_word_cnt(word_cnt), .o_checksum(checksum),
    .o_load_done(load_done), .o_overflow(overflow), .o_timeout(timeout)
  );

  typedef struct packed { logic [27:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: words written, their sum, and the sticky flags.
  int unsigned m_cnt;
  logic [31:0] m_sum;
  bit          m_ovf, m_to, m_done;

  int ack_delay = 1;
  int req_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_sum = '0; m_ovf = 0; m_to = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic check_status();
    logic [27:0] ea;
    ea = BASE + 28'(4 * m_cnt);
    check("word_cnt", word_cnt, 64'(m_cnt));
    check("checksum", checksum, 64'(m_sum));
    check("mem_addr", mem_addr, 64'(ea));
    check("overflow", overflow, 64'(m_ovf));
    check("timeout", timeout, 64'(m_to));
    check("load_done", load_done, 64'(m_done));
  endtask

  task automatic wait_ctrl(input logic [7:0] v, input int budget, input string name);
    int n = 0;
    while (ctrl !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, ctrl, 64'(v));
  endtask

  // One loader transfer; delay is the memory's ack latency in request cycles (beyond TO means never).
  task automatic send_word(input logic [31:0] d, input int delay, input int hold, input bit raise_done);
    bit wr;
    wr = (m_cnt < MAXW);
    if (wr) begin
      exp_q.push_back('{addr: BASE + 28'(4 * m_cnt), data: d});
      if (delay <= TO) begin
        m_cnt++;
        m_sum = m_sum + d;
      end else m_to = 1;
    end else m_ovf = 1;
    ack_delay = delay;
    i_data = d;
    i_we = 1'b1;
    @(negedge clk);
    check("ctrl_latency", ctrl, wr ? 64'd1 : 64'd2);
    if (raise_done) i_done = 1'b1;
    wait_ctrl(8'd2, TO + 4, "ctrl_release");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ctrl_hold", ctrl, 64'd2);
    end
    i_we = 1'b0;
    @(negedge clk);
    check("ctrl_idle", ctrl, 64'd0);
    if (raise_done) begin
      @(negedge clk);
      m_done = 1;
      check("ctrl_finished", ctrl, 64'd3);
    end
    check_status();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_we = 1'b0;
    i_done = 1'b0;
    resetn = 1'b0;
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_ctrl", ctrl, 64'd0);
    check("reset_req", mem_req, 64'd0);
    check_status();
  endtask

  // Memory controller: pulses ack once the request has been seen for ack_delay cycles.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == ack_delay) mem_ack = 1'b1;
      end else req_cyc = 0;
    end
  end

  // Monitor: each new request must match the next expected write and stay stable while held.
  initial begin
    logic prev_req;
    wr_t  e, held;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual addr=0x%0h data=0x%0h required no request", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_data", 64'(mem_wdata), 64'(e.data));
        end
        held = '{addr: mem_addr, data: mem_wdata};
      end else if (mem_req) begin
        check("req_stable", 64'({mem_addr, mem_wdata}), 64'(held));
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    i_we = 1'b0;
    i_done = 1'b0;
    i_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_ctrl", ctrl, 64'd0);
    check_status();

    // Two known words with ack three cycles after request; second held past ack.
    send_word(32'h11223344, 3, 0, 0);
    send_word(32'hA5A5A5A5, 3, 5, 0);

    // Reset while a write is outstanding.
    exp_q.push_back('{addr: BASE + 28'(4 * m_cnt), data: 32'hDEADBEEF});
    ack_delay = 1000;
    i_data = 32'hDEADBEEF;
    i_we = 1'b1;
    @(negedge clk);
    check("mid_ctrl", ctrl, 64'd1);
    check("mid_req", mem_req, 64'd1);
    #2 resetn = 1'b0;
    #1 check("reset_drops_req", mem_req, 64'd0);
    check("reset_drops_ctrl", ctrl, 64'd0);
    i_we = 1'b0;
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_status();

    // Ack latency boundary: TO is the last accepted cycle, TO+1 times out and the address is reused.
    send_word($urandom, TO, 0, 0);
    send_word($urandom, TO + 1, 1, 0);
    send_word($urandom, 1, 0, 0);
    for (int i = 0; i < 10; i++)
      send_word($urandom, $urandom_range(1, TO + 3), $urandom_range(0, 3), 0);
    while (m_cnt < MAXW) send_word($urandom, $urandom_range(1, TO), 0, 0);
    send_word($urandom, 1, 2, 0);
    send_word($urandom, 2, 0, 0);

    // Done raised mid-write completes the write, then finishes on the next idle cycle.
    do_reset();
    send_word($urandom, 2, 1, 1);
    i_we = 1'b1;
    repeat (3) @(negedge clk);
    check("finished_ignores_we", ctrl, 64'd3);
    i_we = 1'b0;
    check_status();

    // Done and write request together in idle: done wins, no request issued.
    do_reset();
    i_data = $urandom;
    i_done = 1'b1;
    i_we = 1'b1;
    @(negedge clk);
    m_done = 1;
    check("done_wins_ctrl", ctrl, 64'd3);
    check("done_wins_req", mem_req, 64'd0);
    i_we = 1'b0;
    @(negedge clk);
    i_we = 1'b1;
    repeat (3) @(negedge clk);
    check("finished_ctrl", ctrl, 64'd3);
    check("finished_req", mem_req, 64'd0);
    check_status();
    i_we = 1'b0;
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
